// File: rtl/mul_share_arbiter_pkg.sv
// mul_arb_pkg: shared definitions for the multiplier-sharing arbiter.
//   - arb_state_e : 3-bit FSM state encoding
//   - *_DEF       : default parameter values (NREQ, WIDTH, TIMEOUT)
//   - to_cnt_width: width of the watchdog counter, clog2(TIMEOUT+1)
//   - rr_wrap     : modulo-n wrap used by the round-robin search
package mul_arb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int WIDTH_DEF    = 16;
    localparam int TIMEOUT_DEF  = 64;
    localparam int TO_CNT_W_DEF = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        RESP      = 3'd5
    } arb_state_e;

    function automatic int to_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Wraps a candidate position back into 0..n-1; v never exceeds 2n-1.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// mul_share_arbiter_if: client and multiplier signals of the arbiter.
//   Client side : req, opA, opB (to arbiter); gnt, ack, res, busy, err (from arbiter)
//   Mult side   : mul_start, mul_a, mul_b (from arbiter); mul_done, mul_p (to arbiter)
// modport master : the arbiter's view.
// modport slave  : the environment's view (clients plus multiplier).
interface mul_share_arbiter_if
    import mul_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] opA;
    logic [NREQ*WIDTH-1:0] opB;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [2*WIDTH-1:0]    res;
    logic                  busy;
    logic                  err;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_p;

    modport master (
        input  req, opA, opB, mul_done, mul_p,
        output gnt, ack, res, busy, err, mul_start, mul_a, mul_b
    );

    modport slave (
        output req, opA, opB, mul_done, mul_p,
        input  gnt, ack, res, busy, err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_arbiter_rr_picker.sv
// mul_rr_picker: combinational round-robin winner selection.
//   req    in  NREQ         request levels
//   last   in  clog2(NREQ)  most recently granted requester
//   onehot out NREQ         one-hot winner (zero when no request)
//   idx    out clog2(NREQ)  winner index
//   valid  out 1            at least one request present
module mul_rr_picker
    import mul_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]         onehot,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    valid
);
    localparam int IW = $clog2(NREQ);

    logic hit_s;

    // Search last+1, last+2, ... (mod NREQ); the first set request wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        hit_s  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                hit_s     = !valid && req[i] && (i == rr_wrap(int'(last) + k, NREQ));
                onehot[i] = onehot[i] | hit_s;
                idx       = hit_s ? IW'(i) : idx;
                valid     = valid | hit_s;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one sequential multiplier among NREQ requesters.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mul_share_arbiter_if.master (client req/opA/opB/gnt/ack/res/busy/err
//          and multiplier mul_start/mul_a/mul_b/mul_done/mul_p)
// Flow: IDLE -> GRANT -> START -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
// Operands are latched at grant; the product is captured when the
// multiplier returns to idle and acked to the granted requester.
// Optional macro MUL_TIMEOUT_EN: watchdog aborting a transaction after
// TIMEOUT cycles with an err pulse and no ack.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mul_share_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_cfg_check
        $error("mul_share_arbiter: NREQ must be 2..8 and TIMEOUT at least 2");
    end

    arb_state_e         state_r;
    arb_state_e         state_nx_s;
    logic [IW-1:0]      last_r;
    logic [NREQ-1:0]    gnt_r;
    logic [NREQ-1:0]    ack_r;
    logic [2*WIDTH-1:0] res_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic               busy_r;
    logic               start_r;
    logic               err_r;
    logic               timeout_s;

    logic [NREQ-1:0]    pick_onehot_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_valid_s;
    logic [WIDTH-1:0]   win_a_s;
    logic [WIDTH-1:0]   win_b_s;

    mul_rr_picker #(.NREQ(NREQ)) u_picker (
        .req    (bus.req),
        .last   (last_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // Operand mux: AND-OR select of the winner's slices.
    always_comb begin
        win_a_s = '0;
        win_b_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_a_s = win_a_s | (bus.opA[i*WIDTH +: WIDTH] & {WIDTH{pick_onehot_s[i]}});
            win_b_s = win_b_s | (bus.opB[i*WIDTH +: WIDTH] & {WIDTH{pick_onehot_s[i]}});
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int TO_W = to_cnt_width(TIMEOUT);

    logic [TO_W-1:0] to_cnt_r;

    // The counter reads k-1 in the k-th cycle after START, so firing at
    // TIMEOUT-2 places the registered err pulse exactly TIMEOUT cycles
    // after the START cycle.
    assign timeout_s = ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) &&
                       (to_cnt_r == TO_W'(TIMEOUT - 2));

    // Watchdog counter: cleared in START, counts in the wait states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_r <= '0;
        end else if (state_r == START) begin
            to_cnt_r <= '0;
        end else if ((state_r == WAIT_BUSY) || (state_r == WAIT_DONE)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic; a normal completion in WAIT_DONE wins over a
    // watchdog expiry in the same cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if ((|bus.req) && bus.mul_done) begin
                    state_nx_s = GRANT;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            GRANT: begin
                // Requests withdrawn before the grant leave nothing to serve.
                if (pick_valid_s) begin
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                state_nx_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timeout_s) begin
                    state_nx_s = IDLE;
                end else if (!bus.mul_done) begin
                    state_nx_s = WAIT_DONE;
                end else begin
                    state_nx_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (bus.mul_done) begin
                    state_nx_s = RESP;
                end else if (timeout_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_DONE;
                end
            end
            RESP: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register plus state-decoded outputs, registered from the next
    // state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            start_r <= 1'b0;
            ack_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            start_r <= (state_nx_s == START);
            ack_r   <= (state_nx_s == RESP) ? gnt_r : '0;
            err_r   <= timeout_s && (state_nx_s == IDLE);
        end
    end

    // Grant, operand latch and round-robin pointer; grant drops on any
    // return to IDLE (normal completion or watchdog abort).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r   <= '0;
            mul_a_r <= '0;
            mul_b_r <= '0;
            last_r  <= IW'(NREQ - 1);
        end else if ((state_r == GRANT) && pick_valid_s) begin
            gnt_r   <= pick_onehot_s;
            mul_a_r <= win_a_s;
            mul_b_r <= win_b_s;
            last_r  <= pick_idx_s;
        end else if (state_nx_s == IDLE) begin
            gnt_r   <= '0;
        end else begin
            gnt_r   <= gnt_r;
        end
    end

    // Result capture on the cycle the multiplier reports done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_r <= '0;
        end else if ((state_r == WAIT_DONE) && bus.mul_done) begin
            res_r <= bus.mul_p;
        end else begin
            res_r <= res_r;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.ack       = ack_r;
    assign bus.res       = res_r;
    assign bus.busy      = busy_r;
    assign bus.err       = err_r;
    assign bus.mul_start = start_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;

endmodule
